// File: rtl/mina_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the MINA DMEM port.
// A store to TXDATA queues a byte; the FSM serialises queued bytes back to back on txd.
module mina_uart_tx #(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wrdata,
  input  logic [3:0]  dmem_wrstb,
  output logic [31:0] dmem_rddata,
  output logic        txd,
  output logic        irq
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [15:0]   frame_div_q, frame_div_d;
  logic          txd_q, txd_d;
  logic          irq_q;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   div_reg_q, div_reg_d;

  logic [1:0]    reg_idx;
  logic          push_req, push_ok, pop, ovf_clr, div_sel;
  logic          fifo_empty, fifo_full, cell_end;
  logic [15:0]   div_eff;
  logic          unused_bits;

  assign reg_idx    = dmem_addr[3:2];
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_FULL);
  assign push_req   = sel && dmem_wrstb[0] && (reg_idx == 2'd0);
  assign push_ok    = push_req && (!fifo_full || pop);
  assign ovf_clr    = sel && dmem_wrstb[0] && (reg_idx == 2'd1) && dmem_wrdata[3];
  assign div_sel    = sel && (reg_idx == 2'd2);
  assign div_eff    = (div_reg_q == 16'd0) ? 16'd1 : div_reg_q;
  assign cell_end   = (cnt_q == 16'(frame_div_q - 16'd1));
  assign unused_bits = ^{dmem_addr[31:4], dmem_addr[1:0], dmem_wrdata[31:16], dmem_wrstb[3:2]};

  // Per-byte-lane update of the divisor register.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_div_lane
      assign div_reg_d[gi*8 +: 8] = (div_sel && dmem_wrstb[gi]) ? dmem_wrdata[gi*8 +: 8]
                                                               : div_reg_q[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    frame_div_d = frame_div_q;
    pop         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          shift_d     = mem_q[rd_ptr_q];
          frame_div_d = div_eff;
          cnt_d       = 16'd0;
          state_d     = S_START;
        end
      end
      S_START: begin
        if (cell_end) begin
          cnt_d     = 16'd0;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (cell_end) begin
          cnt_d = 16'd0;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (cell_end) begin
          cnt_d = 16'd0;
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            pop         = 1'b1;
            shift_d     = mem_q[rd_ptr_q];
            frame_div_d = div_eff;
            state_d     = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop)      count_d = count_q + CNT_ONE;
    else if (!push_ok && pop) count_d = count_q - CNT_ONE;

    ovf_d = ovf_q;
    if (push_req && !push_ok) ovf_d = 1'b1;
    else if (ovf_clr)         ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 16'd0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'd0;
      frame_div_q <= 16'd1;
      txd_q       <= 1'b1;
      irq_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      div_reg_q   <= DIV_RESET;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_div_q <= frame_div_d;
      txd_q       <= txd_d;
      irq_q       <= fifo_empty && (state_q == S_IDLE);
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      div_reg_q   <= div_reg_d;
    end
  end

  // Storage has no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= dmem_wrdata[7:0];
  end

  always_comb begin
    dmem_rddata = 32'd0;
    if (sel) begin
      case (reg_idx)
        2'd1: dmem_rddata = {19'd0, 5'(count_q), 4'd0, ovf_q, (state_q != S_IDLE), fifo_empty, fifo_full};
        2'd2: dmem_rddata = {16'd0, div_reg_q};
        default: dmem_rddata = 32'd0;
      endcase
    end
  end

  assign txd = txd_q;
  assign irq = irq_q;

endmodule

// File: tb/tb_mina_uart_tx.sv
// Bench for mina_uart_tx: directed scenarios plus random traffic, checked every cycle
// against a frame-position model of the serial line, FIFO queue and register map.
module tb_mina_uart_tx;

  localparam int DEPTH   = 16;
  localparam int DIV_RST = 868;

  logic        clk = 1'b0;
  logic        rst_n, sel;
  logic [31:0] addr, wdata, rddata;
  logic [3:0]  strb;
  logic        txd, irq;

  always #5 clk = ~clk;

  mina_uart_tx #(.FIFO_DEPTH(DEPTH), .DIV_RESET(16'(DIV_RST))) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .dmem_addr(addr), .dmem_wrdata(wdata),
    .dmem_wrstb(strb), .dmem_rddata(rddata), .txd(txd), .irq(irq)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] rd_seen;

  // Model: queued bytes, the frame on the wire as (byte, cell width, cycles elapsed).
  byte unsigned m_q[$];
  bit          m_busy;
  int          m_pos, m_fdiv, m_div;
  logic [7:0]  m_byte;
  bit          m_ovf, m_txd, m_irq;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(logic s, logic [31:0] a);
    int n;
    n = m_q.size();
    if (!s) return 32'd0;
    case (a[3:2])
      2'd1: return {19'd0, 5'(n), 4'd0, m_ovf, m_busy, (n == 0), (n == DEPTH)};
      2'd2: return 32'(m_div);
      default: return 32'd0;
    endcase
  endfunction

  // Line level from frame position: start, 8 data bits LSB first, stop.
  function automatic bit m_line();
    int idx;
    if (!m_busy) return 1'b1;
    idx = m_pos / m_fdiv;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return m_byte[idx-1];
    return 1'b1;
  endfunction

  task automatic m_step();
    bit idle_empty, pop, push_req, full_before;
    int div_before;
    if (!rst_n) begin
      m_q.delete();
      m_busy = 0; m_pos = 0; m_fdiv = 1; m_div = DIV_RST; m_ovf = 0;
      m_txd = 1; m_irq = 0;
      return;
    end
    idle_empty  = !m_busy && (m_q.size() == 0);
    full_before = (m_q.size() == DEPTH);
    div_before  = m_div;
    pop = 0;
    if (!m_busy) pop = (m_q.size() > 0);
    else if (m_pos == 10*m_fdiv - 1) begin
      pop = (m_q.size() > 0);
      m_busy = 0;
    end else m_pos++;
    if (pop) begin
      m_byte = m_q.pop_front();
      m_fdiv = (div_before == 0) ? 1 : div_before;
      m_pos  = 0;
      m_busy = 1;
    end
    push_req = sel && strb[0] && (addr[3:2] == 2'd0);
    if (push_req) begin
      if (!full_before || pop) m_q.push_back(wdata[7:0]);
    end
    if (push_req && full_before && !pop) m_ovf = 1;
    else if (sel && strb[0] && addr[3:2] == 2'd1 && wdata[3]) m_ovf = 0;
    if (sel && addr[3:2] == 2'd2) begin
      if (strb[0]) m_div = (m_div & 32'hFF00) | int'(wdata[7:0]);
      if (strb[1]) m_div = (m_div & 32'h00FF) | (int'(wdata[15:8]) << 8);
    end
    m_irq = idle_empty;
    m_txd = m_line();
  endtask

  task automatic cycle(bit s, logic [31:0] a, logic [31:0] d, logic [3:0] w, bit r = 1'b1);
    @(negedge clk);
    sel = s; addr = a; wdata = d; strb = w; rst_n = r;
    #1;
    rd_seen = rddata;
    check("txd", {31'd0, txd}, {31'd0, m_txd});
    check("irq", {31'd0, irq}, {31'd0, m_irq});
    check("rddata", rddata, m_read(s, a));
    @(posedge clk);
    m_step();
  endtask

  task automatic wr(logic [31:0] a, logic [31:0] d, logic [3:0] w = 4'h1);
    cycle(1'b1, a, d, w);
  endtask

  task automatic wait_rd(int n, logic [31:0] a);
    for (int i = 0; i < n; i++) cycle(1'b1, a, 32'd0, 4'h0);
  endtask

  task automatic wait_nosel(int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'($urandom_range(0, 15)), $urandom, 4'h0);
  endtask

  initial begin
    rst_n = 1'b0; sel = 1'b0; addr = 32'd0; wdata = 32'd0; strb = 4'h0;
    repeat (2) @(posedge clk);
    m_step();

    // Reset state
    cycle(1'b0, 32'd0, 32'd0, 4'h0, 1'b0);
    wait_nosel(4);
    wait_rd(1, 32'h4); check("status_after_reset", rd_seen, 32'h2);
    wait_rd(1, 32'h8); check("div_after_reset", rd_seen, 32'd868);
    $display("[TB] reset state checked");

    // Single frame, DIV=4
    wr(32'h8, 32'd4, 4'h3);
    wr(32'h0, 32'h55);
    wait_rd(44, 32'h4);
    wait_rd(1, 32'h4); check("status_after_frame", rd_seen, 32'h2);
    check("irq_after_frame", {31'd0, irq}, 32'd1);
    $display("[TB] DIV=4 frame 0x55 done");

    // Back-to-back frames, DIV=2
    wr(32'h8, 32'd2, 4'h3);
    wr(32'h0, 32'hA1);
    wr(32'h0, 32'h3C);
    wait_rd(50, 32'h4);
    $display("[TB] back-to-back 0xA1 0x3C done");

    // 17 writes at DIV=1: none dropped
    wr(32'h8, 32'd1, 4'h3);
    for (int i = 0; i < 17; i++) wr(32'h0, 32'(i + 8'h30));
    wait_rd(1, 32'h4); check("no_overflow_div1", {31'd0, rd_seen[3]}, 32'd0);
    wait_rd(180, 32'h4);
    $display("[TB] 17 bytes at DIV=1 done");

    // FSM held by DIV=1000: 17th write dropped
    wr(32'h8, 32'd1000, 4'h3);
    wr(32'h0, 32'hEE);
    wait_rd(3, 32'h4);
    for (int i = 0; i < 17; i++) wr(32'h0, 32'(i));
    wait_rd(1, 32'h4); check("status_full_ovf", rd_seen, 32'h100D);
    wr(32'h4, 32'h8);
    wait_rd(1, 32'h4); check("status_ovf_cleared", rd_seen, 32'h1005);
    cycle(1'b0, 32'd0, 32'd0, 4'h0, 1'b0);
    $display("[TB] overflow scenario done");

    // DIV changed 4 -> 8 during the first of two frames
    wr(32'h8, 32'd4, 4'h3);
    wr(32'h0, 32'hC3);
    wr(32'h0, 32'h5A);
    wait_rd(15, 32'h8);
    wr(32'h8, 32'd8, 4'h1);
    wait_rd(120, 32'h4);
    $display("[TB] mid-frame DIV change done");

    // Reset in the middle of DATA with bytes queued
    wr(32'h8, 32'd2, 4'h3);
    wr(32'h0, 32'hF0); wr(32'h0, 32'h0F); wr(32'h0, 32'h99);
    wait_rd(6, 32'h4);
    cycle(1'b1, 32'h4, 32'd0, 4'h0, 1'b0);
    wait_rd(1, 32'h4); check("status_after_abort", rd_seen, 32'h2);
    check("txd_after_abort", {31'd0, txd}, 32'd1);
    wait_nosel(60);
    $display("[TB] mid-frame reset done");

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      int op;
      op = int'($urandom_range(0, 99));
      if (op < 2)       cycle(1'b1, 32'h4, 32'd0, 4'h0, 1'b0);
      else if (op < 10) wr(32'h8, 32'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      else if (op < 35) wr(32'h0, $urandom, 4'($urandom_range(0, 15)));
      else if (op < 40) wr(32'h4, $urandom, 4'($urandom_range(0, 15)));
      else if (op < 43) wr(32'hC, $urandom, 4'hF);
      else              cycle(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), 32'd0, 4'h0);
    end
    $display("[TB] random traffic done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mina_uart_tx.md
# mina_uart_tx

Memory-mapped UART transmitter that sits downstream of the MINA CPU core on its data-memory port, behind the system address decoder. It gets CPU store traffic into a transmit FIFO and serialises the bytes as 8N1 frames on `txd`. Its register reads are combinational because the core's DMEM interface has no wait states.

## Interface
- `FIFO_DEPTH`, 16: transmit FIFO entries. Power of two, ≥2.
- `DIV_RESET`, 868: reset value of the baud divisor, in clk cycles per bit.
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, synchronous, active-low.
- `sel`  in  1: address decoder select. The block is targeted by the current DMEM access.
- `dmem_addr`  in  32 (`u32_t`): byte address. Only bits [3:2] are decoded.
- `dmem_wrdata`  in  32 (`u32_t`): store data.
- `dmem_wrstb`  in  4 (`wrstb_t`): byte write strobes. Bit i enables byte i.
- `dmem_rddata`  out  32 (`u32_t`): read data, combinational from the registers.
- `txd`  out  1: serial output, registered, idle high.
- `irq`  out  1: registered. High when the FIFO is empty and the FSM is IDLE.

## Operation
- Register map (offset = `dmem_addr[3:2]`):
  - 0 TXDATA (write only, reads 0): a write with `sel && dmem_wrstb[0]` pushes `dmem_wrdata[7:0]`.
  - 1 STATUS (read): bit0 full, bit1 empty, bit2 busy (state≠IDLE), bit3 overflow (sticky), bits[8+:5] FIFO count. All other bits read 0. Writing 1 to bit3 with `wrstb[0]` clears overflow.
  - 2 DIV (R/W): bits[15:0] hold the divisor. `wrstb[0]` writes bits[7:0] and `wrstb[1]` writes bits[15:8]. A stored value of 0 is used as 1.
  - 3: reserved. Reads 0, writes ignored.
- `dmem_rddata` is 0 whenever `sel` is low. Reads have no side effects.
- Writes take effect only when `sel` is high. If `dmem_wrstb` is 0, the access is a read.
- FIFO:
  - Circular buffer with read/write pointers of width log2(FIFO_DEPTH) and a count of width log2(FIFO_DEPTH)+1. The pointers wrap modulo the depth.
  - Push while full is dropped and sets overflow. When push and pop coincide, the push is accepted even if the FIFO is full.
  - Push while empty and simultaneous pop cannot occur, because a pop requires the FIFO to be non-empty at the clock edge.
- Transmit FSM, with a bit-cell counter `cnt` and a bit index `bit_idx` of 3 bits:
  - IDLE: `txd`=1. If the FIFO is non-empty, pop into the shift register, latch the effective DIV into `div_q`, set `cnt`=0, and go to START.
  - START: `txd`=0 for `div_q` cycles, then go to DATA with `bit_idx`=0.
  - DATA: `txd`=shift[0] (LSB first). Each bit is held for `div_q` cycles, then the register shifts right. After bit 7, go to STOP.
  - STOP: `txd`=1 for `div_q` cycles. At the end, if the FIFO is non-empty, pop, relatch DIV and go to START directly. Otherwise go to IDLE.
- A DIV write mid-frame does not affect the current frame. It applies from the next pop.
- Reset values:
  - `txd`=1, `irq`=0 (until the first clock after reset).
  - State IDLE; FIFO empty, with pointers and count at 0.
  - overflow=0; DIV=`DIV_RESET`.
  - `dmem_rddata` follows the registers (0 when `sel` is low).
- Reset asserted mid-frame aborts the frame: `txd` is 1 after the next edge, and FIFO contents are discarded.

## Timing
- A TXDATA write is sampled at edge E, and count increments at E.
- From IDLE, the pop occurs at E+1, and `txd` falls at E+1 (registered).
- Frame length is exactly 10×`div_q` cycles (start, 8 data bits, stop).
- Back-to-back frames have zero idle cycles: the next start bit begins on the cycle after the last stop-bit cycle.
- STATUS reflects state registered at the most recent edge. A store in cycle N is visible to a load in cycle N+1.
- `irq` is updated one cycle after empty&&IDLE becomes true or false.

## Test plan
- Reset with no stimulus:
  - `txd`=1 throughout.
  - STATUS read = 0x0000_0002 (empty).
  - DIV read = 868.
- DIV=4, write 0x55:
  - `txd` is low for 4 cycles starting at E+1.
  - Then 1,0,1,0,1,0,1,0, each held 4 cycles.
  - Then high for 4 cycles.
  - Total 40 cycles, after which STATUS busy=0 and `irq`=1.
- DIV=2, write 0xA1 then 0x3C on consecutive cycles:
  - The second start bit begins exactly 20 cycles after the first.
  - STATUS count reads 1 during the first frame and 0 after the second pop.
- DIV=1, write 17 bytes in 17 consecutive cycles:
  - The first byte pops at cycle 2, so all 17 bytes are accepted and none is dropped.
  - Repeat with the FSM held by a DIV of 1000: the 17th write is dropped, STATUS reads full=1 and overflow=1, and count=16.
  - Writing 0x8 to STATUS clears overflow.
- Change DIV from 4 to 8 mid-frame with 2 bytes queued:
  - The first frame is 40 cycles.
  - The second frame is 80 cycles.
- Assert `rst_n` low for 1 cycle during DATA with 3 bytes queued:
  - `txd`=1 at the next edge.
  - STATUS = 0x0000_0002.
  - No further frames are transmitted.
  - Reads with `sel`=0 return 0.
